// File: rtl/note_record_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : note_record_sequencer
//  Description : Records detected pitches into the staff note memory.
//                Generates the eighth-note tempo grid and a metronome
//                count-in, samples note_in once per eighth, packs eight
//                6-bit notes per measure word and rewrites the current
//                measure word after every eighth so partial measures are
//                visible on the display while recording.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_record_sequencer #(
    parameter int EIGHTH_CYCLES   = 37125000,
    parameter int COUNTIN_EIGHTHS = 8,
    parameter int NUM_MEASURES    = 20
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        toggle_in,
    input  logic [5:0]  note_in,
    output logic        wr_en_out,
    output logic [4:0]  wr_addr_out,
    output logic [47:0] wr_data_out,
    output logic        clear_out,
    output logic        click_out,
    output logic [7:0]  eighth_idx_out,
    output logic        busy_out,
    output logic        done_out
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_TICK_W = (EIGHTH_CYCLES > 2) ? $clog2(EIGHTH_CYCLES) : 1;
    localparam int c_CI_W   = $clog2(COUNTIN_EIGHTHS + 1);

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(EIGHTH_CYCLES - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [c_CI_W-1:0]   c_CI_LAST   = c_CI_W'(COUNTIN_EIGHTHS - 1);
    localparam logic [c_CI_W-1:0]   c_CI_ONE    = c_CI_W'(1);
    // Index of the final eighth; its write completes the recording.
    localparam logic [7:0]          c_IDX_LAST  = 8'(NUM_MEASURES * 8 - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COUNTIN = 2'd1,
        S_RECORD  = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                r_state;
    logic                  r_tog_cur;
    logic                  r_tog_prev;
    logic [c_TICK_W-1:0]   r_tick_cnt;
    logic [c_CI_W-1:0]     r_ci_cnt;
    logic [7:0]            r_idx;
    logic [47:0]           r_shadow;
    logic                  r_wr_en;
    logic [4:0]            r_wr_addr;
    logic [47:0]           r_wr_data;
    logic                  r_clear;
    logic                  r_click;
    logic                  r_busy;
    logic                  r_done;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    state_t                w_next_state;
    logic                  w_rise;
    logic                  w_active;
    logic                  w_stop;
    logic                  w_tick;
    logic                  w_ci_tick;
    logic                  w_rec_tick;
    logic                  w_start;
    logic                  w_final_write;
    logic [47:0]           w_shadow_upd;

    // Both toggle history bits reset high so a level already high at reset
    // release is not mistaken for a fresh start request.
    assign w_rise        = r_tog_cur & ~r_tog_prev;
    assign w_active      = (r_state == S_COUNTIN) || (r_state == S_RECORD);
    // A stop pre-empts any tick in the same cycle.
    assign w_stop        = w_active & ~r_tog_cur;
    assign w_tick        = w_active & ~w_stop & (r_tick_cnt == c_TICK_LAST);
    assign w_ci_tick     = w_tick & (r_state == S_COUNTIN);
    assign w_rec_tick    = w_tick & (r_state == S_RECORD);
    assign w_start       = (r_state == S_IDLE) & w_rise;
    assign w_final_write = r_wr_en & (r_state == S_RECORD) & ~w_stop &
                           (r_idx == c_IDX_LAST);

    // Measure word with the current note merged into slot idx[2:0].
    always_comb begin
        w_shadow_upd = r_shadow;
        for (int k = 0; k < 8; k++) begin
            if (r_idx[2:0] == 3'(k)) begin
                w_shadow_upd[6*k +: 6] = note_in;
            end
        end
    end

    // Register the record toggle and keep one cycle of history for edges.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tog_cur  <= 1'b1;
            r_tog_prev <= 1'b1;
        end else begin
            r_tog_cur  <= toggle_in;
            r_tog_prev <= r_tog_cur;
        end
    end

    // State register.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_next_state = S_COUNTIN;
                end
            end
            S_COUNTIN: begin
                if (w_stop) begin
                    w_next_state = S_IDLE;
                end else if (w_ci_tick && (r_ci_cnt == c_CI_LAST)) begin
                    w_next_state = S_RECORD;
                end
            end
            S_RECORD: begin
                if (w_stop) begin
                    w_next_state = S_IDLE;
                end else if (w_final_write) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (!r_tog_cur) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Eighth-note tempo grid: free-runs only while counting in or recording.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_tick_cnt <= '0;
        end else if (w_active && !w_stop) begin
            if (r_tick_cnt == c_TICK_LAST) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_TICK_ONE;
            end
        end else begin
            r_tick_cnt <= '0;
        end
    end

    // Count-in eighths; it is left at its final value once recording starts.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_ci_cnt <= '0;
        end else if (w_start) begin
            r_ci_cnt <= '0;
        end else if (w_ci_tick) begin
            r_ci_cnt <= r_ci_cnt + c_CI_ONE;
        end
    end

    // Eighth index advances once each write has been issued, so the write
    // address and slot stay stable for the whole write cycle.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_idx <= '0;
        end else if (w_start) begin
            r_idx <= '0;
        end else if (r_wr_en) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    // Shadow of the measure being filled; emptied once slot 7 has been taken.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_shadow <= '0;
        end else if (w_start) begin
            r_shadow <= '0;
        end else if (w_rec_tick) begin
            if (r_idx[2:0] == 3'd7) begin
                r_shadow <= '0;
            end else begin
                r_shadow <= w_shadow_upd;
            end
        end
    end

    // Memory write port: one-cycle strobe, address/data held between writes.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_rec_tick;
            if (w_rec_tick) begin
                r_wr_addr <= r_idx[7:3];
                r_wr_data <= w_shadow_upd;
            end
        end
    end

    // Status and metronome pulses, registered from the decoded next state.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_clear <= 1'b0;
            r_click <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_clear <= w_start;
            r_click <= (w_ci_tick & ~r_ci_cnt[0]) | (w_rec_tick & ~r_idx[0]);
            r_busy  <= (w_next_state == S_COUNTIN) || (w_next_state == S_RECORD);
            r_done  <= (w_next_state == S_DONE);
        end
    end

    assign wr_en_out      = r_wr_en;
    assign wr_addr_out    = r_wr_addr;
    assign wr_data_out    = r_wr_data;
    assign clear_out      = r_clear;
    assign click_out      = r_click;
    assign eighth_idx_out = r_idx;
    assign busy_out       = r_busy;
    assign done_out       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_note_record_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_note_record_sequencer
//  Description : Directed/randomized bench for note_record_sequencer with a
//                behavioural model of tempo grid, packing and control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_record_sequencer;

    localparam int EC = 4;
    localparam int CI = 2;
    localparam int NM = 2;
    localparam int NW = NM * 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        toggle = 1'b1;
    logic [5:0]  note = 6'd0;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [47:0] wr_data;
    logic        clear;
    logic        click;
    logic [7:0]  idx;
    logic        busy;
    logic        done;

    note_record_sequencer #(
        .EIGHTH_CYCLES   (EC),
        .COUNTIN_EIGHTHS (CI),
        .NUM_MEASURES    (NM)
    ) dut (
        .pixel_clk_in   (clk),
        .rst_n_in       (rst_n),
        .toggle_in      (toggle),
        .note_in        (note),
        .wr_en_out      (wr_en),
        .wr_addr_out    (wr_addr),
        .wr_data_out    (wr_data),
        .clear_out      (clear),
        .click_out      (click),
        .eighth_idx_out (idx),
        .busy_out       (busy),
        .done_out       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [4:0]  a;
        logic [47:0] d;
    } wr_t;

    wr_t  wq[$];
    int   click_q[$];
    int   clear_q[$];
    wr_t  mon_w;

    // Observation log of strobes, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mon_w.c = cyc;
            mon_w.a = wr_addr;
            mon_w.d = wr_data;
            wq.push_back(mon_w);
        end
        if (click === 1'b1) click_q.push_back(cyc);
        if (clear === 1'b1) clear_q.push_back(cyc);
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Notes planned for each record tick, and the cycle COUNTIN was entered.
    logic [5:0] plan [NW];
    int         B = -1;

    // Measure word expected after eighth k: notes of k's measure up to k.
    function automatic logic [47:0] exp_word(input int k);
        logic [47:0] w;
        int base;
        w = '0;
        base = (k / 8) * 8;
        for (int j = base; j <= k; j++) w[(j - base) * 6 +: 6] = plan[j];
        return w;
    endfunction

    // Record tick k is the cycle ending at edge B+EC*(CI+1)+EC*k; present the
    // planned note during it, random filler everywhere else.
    task automatic drive_note();
        int off;
        off = cyc - (B + EC * (CI + 1) - 1);
        if (B >= 0 && off >= 0 && (off % EC) == 0 && (off / EC) < NW)
            note = plan[off / EC];
        else
            note = 6'($urandom);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
        drive_note();
    endtask

    task automatic start_run(input string tag);
        int c0;
        wq.delete();
        click_q.delete();
        clear_q.delete();
        B = -1;
        toggle = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            step();
            if (busy === 1'b1) begin
                B = cyc;
                break;
            end
        end
        chk({tag, "_busy_seen"}, 64'(B >= 0), 64'd1);
        if (B < 0) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $fatal(1, "FAIL %s: busy_out never rose", tag);
        end
        chk({tag, "_start_latency"}, 64'(B - c0), 64'd2);
        chk({tag, "_clear_with_busy"}, 64'(clear), 64'd1);
    endtask

    task automatic check_writes(input string tag, input int nexp);
        chk({tag, "_write_count"}, 64'(wq.size()), 64'(nexp));
        for (int k = 0; k < nexp && k < wq.size(); k++) begin
            chk($sformatf("%s_w%0d_cycle", tag, k), 64'(wq[k].c), 64'(B + EC * (CI + 1) + EC * k));
            chk($sformatf("%s_w%0d_addr", tag, k), 64'(wq[k].a), 64'(k / 8));
            chk($sformatf("%s_w%0d_data", tag, k), 64'(wq[k].d), 64'(exp_word(k)));
        end
    endtask

    int exp_clicks[$];

    initial begin
        // ---------------- Reset ----------------
        for (int i = 0; i < NW; i++) plan[i] = 6'(8'h20 + i);
        repeat (3) step();
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_clear", 64'(clear), 64'd0);
        chk("rst_click", 64'(click), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (6) step();
        chk("rel_high_busy", 64'(busy), 64'd0);
        chk("rel_high_no_clear", 64'(clear_q.size()), 64'd0);
        toggle = 1'b0;
        repeat (3) step();

        // ---------------- Run A: directed packing to auto-stop ----------------
        start_run("A");
        step();
        chk("A_clear_one_cycle", 64'(clear), 64'd0);
        while (cyc < B + EC * (CI + 1) + EC * (NW - 1)) step();
        chk("A_final_write_strobe", 64'(wr_en), 64'd1);
        chk("A_done_not_yet", 64'(done), 64'd0);
        step();
        chk("A_done", 64'(done), 64'd1);
        chk("A_busy_in_done", 64'(busy), 64'd0);
        chk("A_idx_final", 64'(idx), 64'(NW));
        repeat (20) step();
        chk("A_done_held", 64'(done), 64'd1);
        check_writes("A", NW);
        if (wq.size() >= 9) begin
            chk("A_w7_full_measure", 64'(wq[7].d),
                64'({6'h27, 6'h26, 6'h25, 6'h24, 6'h23, 6'h22, 6'h21, 6'h20}));
            chk("A_w8_new_measure", 64'(wq[8].d), 64'h28);
        end
        exp_clicks.delete();
        for (int i = 0; i < CI; i++)
            if (i % 2 == 0) exp_clicks.push_back(B + EC * (i + 1));
        for (int k = 0; k < NW; k++)
            if (k % 2 == 0) exp_clicks.push_back(B + EC * (CI + 1) + EC * k);
        chk("A_click_count", 64'(click_q.size()), 64'(exp_clicks.size()));
        for (int i = 0; i < exp_clicks.size() && i < click_q.size(); i++)
            chk($sformatf("A_click%0d_cycle", i), 64'(click_q[i]), 64'(exp_clicks[i]));
        chk("A_clear_count", 64'(clear_q.size()), 64'd1);
        toggle = 1'b0;
        step();
        step();
        chk("A_idle_done", 64'(done), 64'd0);
        chk("A_idle_busy", 64'(busy), 64'd0);
        chk("A_idx_retained", 64'(idx), 64'(NW));

        // ---------------- Run B: random notes, early stop at tick 3 ----------------
        for (int i = 0; i < NW; i++) plan[i] = 6'($urandom);
        start_run("B");
        chk("B_idx_cleared", 64'(idx), 64'd0);
        while (cyc < B + EC * (CI + 1) + EC * 3 - 2) step();
        toggle = 1'b0;
        step();
        chk("B_busy_before_stop", 64'(busy), 64'd1);
        step();
        chk("B_idle_after_stop", 64'(busy), 64'd0);
        repeat (15) step();
        check_writes("B", 3);
        chk("B_idx_retained", 64'(idx), 64'd3);
        chk("B_addr_held", 64'(wr_addr), 64'd0);
        chk("B_data_held", 64'(wr_data), 64'(exp_word(2)));
        chk("B_done_low", 64'(done), 64'd0);

        // ---------------- Run C: async reset between tick and write ----------------
        for (int i = 0; i < NW; i++) plan[i] = 6'($urandom);
        start_run("C");
        while (cyc < B + EC * (CI + 1) - 1) step();
        chk("C_busy_before_reset", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("C_rst_busy", 64'(busy), 64'd0);
        chk("C_rst_idx", 64'(idx), 64'd0);
        chk("C_rst_data", 64'(wr_data), 64'd0);
        chk("C_rst_clear", 64'({wr_en, clear, click, done}), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("C_no_write", 64'(wq.size()), 64'd0);
        chk("C_no_restart", 64'(busy), 64'd0);
        chk("C_clear_once", 64'(clear_q.size()), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/note_record_sequencer.md
# note_record_sequencer

Controller that sequences recording of detected pitches into the 20-measure note memory read by the staff display. It generates the eighth-note tempo grid and a metronome count-in, samples `note_in` once per eighth, packs eight 6-bit notes per measure word, and drives the memory's write port. After every eighth it rewrites the current measure word, so the display shows partial measures live.

## Interface
- `EIGHTH_CYCLES`, default 37125000: clock cycles per eighth note (≥2).
- `COUNTIN_EIGHTHS`, default 8: eighths of count-in before recording (≥1).
- `NUM_MEASURES`, default 20: measures recorded before auto-stop (1..32).
- `pixel_clk_in`  input  1  sole clock.
- `rst_n_in`  input  1  reset, asynchronous, active-low.
- `toggle_in`  input  1  record enable level; rising edge starts, low stops.
- `note_in`  input  6  current detected note; bit 5 = 0 means rest.
- `wr_en_out`  output  1  one-cycle write strobe to the note memory.
- `wr_addr_out`  output  5  measure address = eighth index / 8.
- `wr_data_out`  output  48  measure word; slot k in bits [6k+5:6k].
- `clear_out`  output  1  one-cycle pulse requesting a display/memory clear at start.
- `click_out`  output  1  one-cycle metronome pulse.
- `eighth_idx_out`  output  8  number of eighths recorded so far.
- `busy_out`  output  1  high in COUNTIN or RECORD.
- `done_out`  output  1  high in DONE.

## Operation
- States: IDLE, COUNTIN, RECORD, DONE.
- `toggle_in` is registered once. A rising edge is current=1 and previous=0.
- IDLE:
  - On a rising edge: go to COUNTIN, pulse `clear_out`, zero the tick counter, eighth index, count-in counter and shadow measure.
  - A level-high `toggle_in` with no edge does not start recording.
- Tick counter:
  - Counts 0..EIGHTH_CYCLES-1 in COUNTIN and RECORD, then wraps.
  - The tick is the cycle where the count equals EIGHTH_CYCLES-1.
  - The counter is held at 0 in IDLE and DONE.
- COUNTIN:
  - Each tick increments the count-in counter.
  - `click_out` pulses on count-in ticks 0, 2, 4, … (quarter beats).
  - On tick number COUNTIN_EIGHTHS-1, go to RECORD. The counter does not reset.
- RECORD, on each tick:
  - Write `note_in` into shadow slot idx[2:0].
  - Next cycle: assert `wr_en_out` with `wr_addr_out` = idx[7:3] and `wr_data_out` = shadow including the new note. Unfilled slots are 0.
  - Then increment idx.
  - After slot 7 is written, clear the shadow for the next measure.
  - `click_out` pulses on ticks where idx[0]=0.
- DONE:
  - Reached after the write with idx = NUM_MEASURES*8-1, when idx reaches NUM_MEASURES*8.
  - Stay in DONE until `toggle_in` is low, then go to IDLE.
- `toggle_in` low in COUNTIN or RECORD: go to IDLE next cycle.
  - No further writes are issued.
  - A write already registered for that cycle still completes.
  - Memory contents and `eighth_idx_out` are retained until the next start.
- A stop and a tick in the same cycle: stop wins. No sample is taken and no write is issued.
- Notes, including rests (bit 5 = 0), are stored verbatim. No filtering.

## Timing
- Reset values:
  - State IDLE.
  - All outputs 0: `wr_en_out`, `wr_addr_out`, `wr_data_out`, `clear_out`, `click_out`, `eighth_idx_out`, `busy_out`, `done_out`.
- Reset mid-operation aborts immediately (asynchronous). Any pending write is dropped.
- Start latency:
  - A `toggle_in` rise is seen 1 cycle later.
  - `clear_out` and `busy_out` assert the cycle after that.
- The first count-in tick occurs EIGHTH_CYCLES cycles after entering COUNTIN.
- The first record tick occurs (COUNTIN_EIGHTHS+1)·EIGHTH_CYCLES cycles after entering COUNTIN.
- `note_in` is sampled on the tick edge. `wr_en_out` is high exactly 1 cycle, the cycle after the tick.
- Address and data are valid in that cycle and hold their values until the next write.
- `eighth_idx_out` updates in the cycle after `wr_en_out`.
- `done_out` asserts the cycle after the final write.
- All outputs are registered. No combinational input-to-output path.

## Test plan
Bench parameters: EIGHTH_CYCLES=4, COUNTIN_EIGHTHS=2, NUM_MEASURES=2.

- **Reset:** hold `rst_n_in`=0, drive `toggle_in`=1 → all outputs 0. Release reset with `toggle_in` held high → stays IDLE, no `clear_out`.
- **Count-in:** raise `toggle_in` → `clear_out` pulses once, then 2 ticks with `click_out` on the first only. The first `wr_en_out` comes 12 cycles after `busy_out` rises.
- **Measure packing:** drive `note_in` = 6'h20+k at record tick k.
  - Write k has addr 0, data slots 0..k filled, upper slots 0.
  - Write 7 data = {27,26,…,20}h packed.
  - Write 8 has addr 1 with only slot 0 = 6'h28.
- **Auto-stop:** after 16 writes (addr 1 last), `done_out`=1 and no 17th write. Dropping `toggle_in` gives IDLE; `eighth_idx_out` stays 16.
- **Early stop:** drop `toggle_in` in the same cycle as record tick 3 → exactly 3 writes, no write for slot 3, IDLE 2 cycles later.
- **Async reset mid-record:** pulse `rst_n_in` low between a tick and its write → no `wr_en_out`, all outputs 0 immediately.
